// File: rtl/fifo_burst_reader_if.sv
// FIFO read-port bundle between the burst reader (master) and the FIFO (slave).
// Carries the status flags, the read enable and the FIFO data output.
interface fifo_burst_reader_if #(
  parameter int unsigned DW = 8
);
  logic          full;
  logic          empty;
  logic          rd_rst_busy;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;

  modport master (
    input  full,
    input  empty,
    input  rd_rst_busy,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output full,
    output empty,
    output rd_rst_busy,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: waits for a synchronised full, drains the FIFO in one burst,
// checks the words form an incrementing sequence and reports burst length / error count.
module fifo_burst_reader #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CW     = 9,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DLY    = 10
) (
  input  logic                       rd_clk,
  input  logic                       rst,
  fifo_burst_reader_if.master        fifo,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_word,
  output logic [CW-1:0]              burst_len,
  output logic [15:0]                err_cnt,
  output logic                       err_flag,
  output logic                       busy
);
  localparam int unsigned TW = $clog2(DLY + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                full_meta_q, full_s_q, full_s_prev_q;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [RD_LAT-1:0]   v_pipe_q, v_pipe_d;
  logic                first_q, first_d;
  logic [DW-1:0]       exp_q, exp_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DW-1:0]       rd_word_q, rd_word_d;
  logic [CW-1:0]       burst_len_q, burst_len_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_flag_q, err_flag_d;

  logic start;
  logic rd_en;
  logic v;

  assign start = full_s_q & ~full_s_prev_q;
  assign rd_en = (state_q == READ) & ~fifo.empty & ~fifo.rd_rst_busy;
  assign v     = v_pipe_q[RD_LAT-1];

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    wcnt_d      = wcnt_q;
    burst_len_d = burst_len_q;
    first_d     = first_q;
    exp_d       = exp_q;
    rd_valid_d  = v;
    rd_word_d   = rd_word_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;

    v_pipe_d    = '0;
    v_pipe_d[0] = rd_en;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      v_pipe_d[i] = v_pipe_q[i-1];
    end

    unique case (state_q)
      IDLE: begin
        // The detection cycle counts as the first of the DLY cycles after full_s rises.
        if (start && !fifo.rd_rst_busy) begin
          state_d = WAIT;
          tmr_d   = TW'(1);
        end
      end
      WAIT: begin
        if (tmr_q >= TW'(DLY - 1)) begin
          state_d = READ;
          wcnt_d  = '0;
          first_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      READ: begin
        if (fifo.empty) begin
          state_d = DRAIN;
          tmr_d   = '0;
        end else if (rd_en && (wcnt_q != '1)) begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (tmr_q >= TW'(RD_LAT - 1)) begin
          state_d     = IDLE;
          burst_len_d = wcnt_q;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (v) begin
      rd_word_d = fifo.fifo_rd_data;
      exp_d     = fifo.fifo_rd_data + DW'(1);
      first_d   = 1'b0;
      if (!first_q && (fifo.fifo_rd_data != exp_q)) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      full_meta_q   <= 1'b0;
      full_s_q      <= 1'b0;
      full_s_prev_q <= 1'b0;
      tmr_q         <= '0;
      wcnt_q        <= '0;
      v_pipe_q      <= '0;
      first_q       <= 1'b0;
      exp_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_word_q     <= '0;
      burst_len_q   <= '0;
      err_cnt_q     <= '0;
      err_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_meta_q   <= fifo.full;
      full_s_q      <= full_meta_q;
      full_s_prev_q <= full_s_q;
      tmr_q         <= tmr_d;
      wcnt_q        <= wcnt_d;
      v_pipe_q      <= v_pipe_d;
      first_q       <= first_d;
      exp_q         <= exp_d;
      rd_valid_q    <= rd_valid_d;
      rd_word_q     <= rd_word_d;
      burst_len_q   <= burst_len_d;
      err_cnt_q     <= err_cnt_d;
      err_flag_q    <= err_flag_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en;
  assign rd_valid        = rd_valid_q;
  assign rd_word         = rd_word_q;
  assign burst_len       = burst_len_q;
  assign err_cnt         = err_cnt_q;
  assign err_flag        = err_flag_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=2,
// each fed by a small behavioural FIFO model.
module tb_fifo_burst_reader;
  localparam int unsigned DLY = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        full_r   [2];
  logic        rbusy_r  [2];
  logic        empty_r  [2] = '{1'b1, 1'b1};
  logic [7:0]  d1       [2];
  logic [7:0]  d2       [2];
  logic        rd_en_w  [2];
  logic        rd_valid_w [2];
  logic [7:0]  rd_word_w  [2];
  logic [8:0]  blen_w   [2];
  logic [15:0] err_w    [2];
  logic        flag_w   [2];
  logic        busy_w   [2];
  logic [7:0]  fq  [2][$];
  logic [7:0]  obs [2][$];
  int unsigned en_cnt  [2] = '{0, 0};
  int unsigned gap_cnt [2] = '{0, 0};
  logic [7:0]  exp_words[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_burst_reader_if #(.DW(8)) ifc ();
    assign ifc.full         = full_r[g];
    assign ifc.empty        = empty_r[g];
    assign ifc.rd_rst_busy  = rbusy_r[g];
    assign ifc.fifo_rd_data = (g == 0) ? d1[g] : d2[g];
    assign rd_en_w[g]       = ifc.fifo_rd_en;

    fifo_burst_reader #(.DW(8), .CW(9), .RD_LAT(g + 1), .DLY(DLY)) dut (
      .rd_clk    (clk),
      .rst       (rst),
      .fifo      (ifc),
      .rd_valid  (rd_valid_w[g]),
      .rd_word   (rd_word_w[g]),
      .burst_len (blen_w[g]),
      .err_cnt   (err_w[g]),
      .err_flag  (flag_w[g]),
      .busy      (busy_w[g])
    );

    logic [7:0] pop_w;
    logic       seen = 1'b0;

    always @(posedge clk) begin
      if (rd_en_w[g] && fq[g].size() != 0) begin
        pop_w = fq[g].pop_front();
        d1[g] <= pop_w;
      end
      d2[g]      <= d1[g];
      empty_r[g] <= (fq[g].size() == 0);
    end

    always @(negedge clk) begin
      if (rd_valid_w[g]) obs[g].push_back(rd_word_w[g]);
      if (rd_en_w[g]) en_cnt[g]++;
      if (busy_w[g] && seen && !rd_en_w[g] && !empty_r[g]) gap_cnt[g]++;
      if (!busy_w[g]) seen = 1'b0;
      else if (rd_en_w[g]) seen = 1'b1;
    end
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_burst(input int unsigned k, input int unsigned exp_len,
                           input int unsigned exp_err, input logic exp_flag,
                           input int unsigned pulse_at);
    int unsigned n, en0, gap0, ob0, bad;
    @(posedge clk); #1;
    foreach (exp_words[i]) fq[k].push_back(exp_words[i]);
    repeat (3) @(posedge clk);
    #1;
    en0  = en_cnt[k];
    gap0 = gap_cnt[k];
    ob0  = obs[k].size();
    full_r[k] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!rd_en_w[k] && n < 100);
    check($sformatf("start_dly%0d", k), n, DLY + 2);
    if (pulse_at != 0) begin
      n = 0;
      while ((en_cnt[k] - en0) < pulse_at && n < 1000) begin
        @(negedge clk); n++;
      end
      @(posedge clk); #1 rbusy_r[k] = 1'b1;
      repeat (3) @(posedge clk);
      #1 rbusy_r[k] = 1'b0;
    end
    n = 0;
    while (busy_w[k] && n < 2000) begin
      @(negedge clk); n++;
    end
    check($sformatf("idle_reached%0d", k), (n < 2000), 1);
    repeat (3) @(negedge clk);
    check($sformatf("burst_len%0d", k), blen_w[k], exp_len);
    check($sformatf("err_cnt%0d", k), err_w[k], exp_err);
    check($sformatf("err_flag%0d", k), flag_w[k], exp_flag);
    check($sformatf("valid_cnt%0d", k), obs[k].size() - ob0, exp_words.size());
    check($sformatf("rd_en_cnt%0d", k), en_cnt[k] - en0, exp_words.size());
    check($sformatf("gap_cycles%0d", k), gap_cnt[k] - gap0, (pulse_at != 0) ? 3 : 0);
    bad = 0;
    foreach (exp_words[i]) begin
      if (ob0 + i >= obs[k].size() || obs[k][ob0 + i] != exp_words[i]) bad++;
    end
    check($sformatf("data%0d", k), bad, 0);
    @(posedge clk); #1 full_r[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    full_r  = '{1'b1, 1'b1};
    rbusy_r = '{1'b0, 1'b0};
    rst     = 1'b1;

    // Reset with full held high: everything cleared.
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rd_en%0d", k), rd_en_w[k], 0);
      check($sformatf("rst_rd_valid%0d", k), rd_valid_w[k], 0);
      check($sformatf("rst_rd_word%0d", k), rd_word_w[k], 0);
      check($sformatf("rst_burst_len%0d", k), blen_w[k], 0);
      check($sformatf("rst_err_cnt%0d", k), err_w[k], 0);
      check($sformatf("rst_err_flag%0d", k), flag_w[k], 0);
      check($sformatf("rst_busy%0d", k), busy_w[k], 0);
    end

    // Releasing reset with full high is a rising full_s: burst on an empty FIFO.
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    while (!busy_w[0] && n < 50) begin @(negedge clk); n++; end
    check("empty_burst_start", busy_w[0], 1);
    n = 0;
    while (busy_w[0] && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("empty_burst_idle", busy_w[0], 0);
    check("empty_burst_len", blen_w[0], 0);
    check("empty_burst_valid", obs[0].size(), 0);
    @(posedge clk); #1 full_r = '{1'b0, 1'b0};

    for (int unsigned k = 0; k < 2; k++) begin
      exp_words.delete();
      for (int i = 0; i < 255; i++) exp_words.push_back(8'(i));
      run_burst(k, 255, 0, 1'b0, 0);
      exp_words = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      run_burst(k, 4, 0, 1'b0, 0);
    end

    exp_words = '{8'd3, 8'd4, 8'd9, 8'd10, 8'd12};
    run_burst(0, 5, 2, 1'b1, 0);
    exp_words.delete();
    for (int i = 20; i < 30; i++) exp_words.push_back(8'(i));
    run_burst(0, 10, 2, 1'b1, 0);

    // full_s rises while rd_rst_busy is high: start ignored.
    @(posedge clk); #1 rbusy_r[1] = 1'b1;
    @(posedge clk); #1 full_r[1] = 1'b1;
    n = 0;
    repeat (20) begin @(negedge clk); if (busy_w[1]) n++; end
    check("rrb_no_start", n, 0);
    @(posedge clk); #1 rbusy_r[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rrb_still_idle", busy_w[1], 0);
    @(posedge clk); #1 full_r[1] = 1'b0;

    exp_words.delete();
    for (int i = 50; i < 80; i++) exp_words.push_back(8'(i));
    run_burst(1, 30, 0, 1'b0, 5);

    // Reset in the middle of a burst.
    exp_words.delete();
    for (int i = 0; i < 100; i++) fq[0].push_back(8'(i));
    repeat (3) @(posedge clk);
    #1 full_r[0] = 1'b1;
    n = 0;
    while (en_cnt[0] < 40 + 255 + 4 + 5 + 10 && n < 200) begin @(negedge clk); n++; end
    check("mid_reset_reached_40", (n < 200), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_en", rd_en_w[0], 0);
    check("mid_rst_busy", busy_w[0], 0);
    check("mid_rst_rd_valid", rd_valid_w[0], 0);
    check("mid_rst_burst_len", blen_w[0], 0);
    check("mid_rst_err_cnt", err_w[0], 0);
    check("mid_rst_err_flag", flag_w[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    full_r[0] = 1'b0;
    fq[0].delete();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
